// File: rtl/ct_ifu_icache_pkg.sv
// Shared types and constants for the IFU icache refill write path.
// The FSM encoding, line geometry and bank parity helper live here.
package ct_ifu_icache_pkg;

  typedef enum logic [1:0] {
    REFILL_IDLE = 2'd0,
    REFILL_FILL = 2'd1,
    REFILL_DONE = 2'd2
  } refill_state_e;

  localparam int unsigned NUM_BANKS  = 4;
  localparam int unsigned BANK_W     = 32;
  localparam int unsigned IDX_OFF_W  = 4;
  localparam int unsigned BEAT_CNT_W = 2;
  localparam int unsigned ACC_CNT_W  = 3;

  localparam logic [ACC_CNT_W-1:0]  BEATS_PER_LINE = 3'd4;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT      = 2'd3;

  // Bank 0 is the most significant word of a beat; bit i is bank i's even parity.
  function automatic logic [NUM_BANKS-1:0] bank_parity(
    input logic [NUM_BANKS*BANK_W-1:0] beat
  );
    logic [NUM_BANKS-1:0] par;
    par = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      par[i] = ^beat[(NUM_BANKS-1-i)*BANK_W +: BANK_W];
    end
    return par;
  endfunction

endpackage

// File: rtl/ct_ifu_icache_refill_buf.sv
// One-entry refill beat buffer with its valid flag.
// ICACHE_REFILL_PARITY_EN adds per-bank parity captured with the beat.
module ct_ifu_icache_refill_buf
  import ct_ifu_icache_pkg::*;
#(
  parameter int BEAT_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic              flush_i,
  input  logic [BEAT_W-1:0] data_i,
  output logic              buf_vld_o,
  output logic [BEAT_W-1:0] buf_data_o
`ifdef ICACHE_REFILL_PARITY_EN
  ,
  output logic [NUM_BANKS-1:0] buf_par_o
`endif
);

  logic              vld_q, vld_d;
  logic [BEAT_W-1:0] data_q, data_d;

  // A load and a drain in the same cycle leave the entry full with the new beat.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d  = 1'b1;
      data_d = data_i;
    end else if (drain_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign buf_vld_o  = vld_q;
  assign buf_data_o = data_q;

`ifdef ICACHE_REFILL_PARITY_EN
  logic [NUM_BANKS-1:0] par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (!flush_i && load_i) begin
      par_d = bank_parity(data_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign buf_par_o = par_q;
`endif

endmodule

// File: rtl/ct_ifu_icache_refill_wr.sv
// Icache data array 0 refill write controller: buffers four L2 beats and writes each
// across all four banks, yielding to fetch reads. Optional ICACHE_REFILL_PARITY_EN adds refill_par.
module ct_ifu_icache_refill_wr
  import ct_ifu_icache_pkg::*;
#(
  parameter int INDEX_W = 16,
  parameter int BEAT_W  = 128
) (
  input  logic                                    forever_cpuclk,
  input  logic                                    cpurst_b,
  input  logic                                    refill_req_vld,
  input  logic [INDEX_W-BEAT_CNT_W-IDX_OFF_W-1:0] refill_req_index,
  output logic                                    refill_req_rdy,
  input  logic                                    l2_refill_data_vld,
  input  logic [BEAT_W-1:0]                       l2_refill_data,
  output logic                                    l2_refill_data_rdy,
  input  logic                                    ifu_fetch_rd_vld,
  input  logic                                    ifu_icache_refill_flush,
  output logic                                    refill_wr_vld,
  output logic [NUM_BANKS-1:0]                    refill_bank_cen_b,
  output logic [NUM_BANKS-1:0]                    refill_bank_clk_en,
  output logic                                    refill_wen_b,
  output logic [INDEX_W-1:0]                      refill_index,
  output logic [BEAT_W-1:0]                       refill_din,
  output logic                                    refill_busy,
  output logic                                    refill_done,
  output refill_state_e                           refill_dbg_state
`ifdef ICACHE_REFILL_PARITY_EN
  ,
  output logic [NUM_BANKS-1:0]                    refill_par
`endif
);

  localparam int LINE_IDX_W = INDEX_W - BEAT_CNT_W - IDX_OFF_W;

  // Handshakes: a request is taken when refill_req_vld & refill_req_rdy, a beat when
  // l2_refill_data_vld & l2_refill_data_rdy, both on the rising clock edge; the sender
  // holds valid and payload stable until taken, and ready never waits on valid.

  refill_state_e          state_q, state_d;
  logic [LINE_IDX_W-1:0]  index_q, index_d;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ACC_CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

  logic                   buf_vld;
  logic [BEAT_W-1:0]      buf_data;
  logic                   flush;
  logic                   wr_fire;
  logic                   last_write;
  logic                   req_accept;
  logic                   beat_accept;

  assign flush       = ifu_icache_refill_flush;
  // Flush outranks a pending write so an aborted line never touches the array again.
  assign wr_fire     = buf_vld & ~ifu_fetch_rd_vld & ~flush;
  assign last_write  = wr_fire & (beat_cnt_q == LAST_BEAT);
  assign req_accept  = (state_q == REFILL_IDLE) & refill_req_vld & ~flush;
  assign beat_accept = l2_refill_data_vld & l2_refill_data_rdy;

  ct_ifu_icache_refill_buf #(
    .BEAT_W (BEAT_W)
  ) u_refill_buf (
    .clk_i      (forever_cpuclk),
    .rst_n_i    (cpurst_b),
    .load_i     (beat_accept),
    .drain_i    (wr_fire),
    .flush_i    (flush),
    .data_i     (l2_refill_data),
    .buf_vld_o  (buf_vld),
    .buf_data_o (buf_data)
`ifdef ICACHE_REFILL_PARITY_EN
    ,
    .buf_par_o  (refill_par)
`endif
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= REFILL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = REFILL_IDLE;
    end else begin
      unique case (state_q)
        REFILL_IDLE: if (refill_req_vld) state_d = REFILL_FILL;
        REFILL_FILL: if (last_write)     state_d = REFILL_DONE;
        REFILL_DONE:                     state_d = REFILL_IDLE;
        default:                         state_d = REFILL_IDLE;
      endcase
    end
  end

  always_comb begin
    refill_req_rdy     = (state_q == REFILL_IDLE);
    refill_busy        = (state_q != REFILL_IDLE);
    refill_done        = (state_q == REFILL_DONE);
    refill_dbg_state   = state_q;
    l2_refill_data_rdy = (state_q == REFILL_FILL) & (acc_cnt_q < BEATS_PER_LINE) &
                         (~buf_vld | wr_fire);
    refill_wr_vld      = wr_fire;
    refill_bank_cen_b  = wr_fire ? '0 : '1;
    refill_bank_clk_en = wr_fire ? '1 : '0;
    refill_wen_b       = ~wr_fire;
    refill_index       = {index_q, beat_cnt_q, {IDX_OFF_W{1'b0}}};
    refill_din         = buf_data;
  end

  // beat_cnt wraps 3->0 on the fourth write, so DONE presents the line's base index.
  always_comb begin
    index_d    = index_q;
    beat_cnt_d = beat_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    if (flush) begin
      beat_cnt_d = '0;
      acc_cnt_d  = '0;
    end else if (req_accept) begin
      index_d    = refill_req_index;
      beat_cnt_d = '0;
      acc_cnt_d  = '0;
    end else begin
      if (wr_fire) begin
        beat_cnt_d = beat_cnt_q + 2'd1;
      end
      if (beat_accept && (acc_cnt_q != BEATS_PER_LINE)) begin
        acc_cnt_d = acc_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      index_q    <= '0;
      beat_cnt_q <= '0;
      acc_cnt_q  <= '0;
    end else begin
      index_q    <= index_d;
      beat_cnt_q <= beat_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

endmodule

// File: tb/tb_ct_ifu_icache_refill_wr.sv
// Directed bench for ct_ifu_icache_refill_wr: writes and done pulses are checked by a
// monitor against expected queues; handshake and reset behaviour are checked inline.
module tb_ct_ifu_icache_refill_wr;
  import ct_ifu_icache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          refill_req_vld;
  logic [9:0]    refill_req_index;
  logic          refill_req_rdy;
  logic          l2_refill_data_vld;
  logic [127:0]  l2_refill_data;
  logic          l2_refill_data_rdy;
  logic          ifu_fetch_rd_vld;
  logic          ifu_icache_refill_flush;
  logic          refill_wr_vld;
  logic [3:0]    refill_bank_cen_b;
  logic [3:0]    refill_bank_clk_en;
  logic          refill_wen_b;
  logic [15:0]   refill_index;
  logic [127:0]  refill_din;
  logic          refill_busy;
  logic          refill_done;
  refill_state_e refill_dbg_state;
`ifdef ICACHE_REFILL_PARITY_EN
  logic [3:0]    refill_par;
`endif

  ct_ifu_icache_refill_wr dut (
    .forever_cpuclk          (clk),
    .cpurst_b                (rst_n),
    .refill_req_vld          (refill_req_vld),
    .refill_req_index        (refill_req_index),
    .refill_req_rdy          (refill_req_rdy),
    .l2_refill_data_vld      (l2_refill_data_vld),
    .l2_refill_data          (l2_refill_data),
    .l2_refill_data_rdy      (l2_refill_data_rdy),
    .ifu_fetch_rd_vld        (ifu_fetch_rd_vld),
    .ifu_icache_refill_flush (ifu_icache_refill_flush),
    .refill_wr_vld           (refill_wr_vld),
    .refill_bank_cen_b       (refill_bank_cen_b),
    .refill_bank_clk_en      (refill_bank_clk_en),
    .refill_wen_b            (refill_wen_b),
    .refill_index            (refill_index),
    .refill_din              (refill_din),
    .refill_busy             (refill_busy),
    .refill_done             (refill_done),
    .refill_dbg_state        (refill_dbg_state)
`ifdef ICACHE_REFILL_PARITY_EN
    ,
    .refill_par              (refill_par)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [143:0] exp_q[$];       // {refill_index, refill_din} per expected write
  logic [15:0]  exp_done_q[$];  // line base index expected on each refill_done
  int n_checks;
  int n_pass;
  int last_wr_cyc;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_line(input logic [9:0] idx, input logic [127:0] b0, input logic [127:0] b1,
                           input logic [127:0] b2, input logic [127:0] b3);
    logic [15:0] base;
    base = {idx, 6'd0};
    exp_q.push_back({base | 16'h0000, b0});
    exp_q.push_back({base | 16'h0010, b1});
    exp_q.push_back({base | 16'h0020, b2});
    exp_q.push_back({base | 16'h0030, b3});
    exp_done_q.push_back(base);
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  initial begin
    logic [143:0] e;
    logic [15:0]  d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (refill_wr_vld) begin
          check("wr_expected", 144'(exp_q.size() != 0), 144'(1));
          check("wr_strobes", 144'({refill_bank_cen_b, refill_bank_clk_en, refill_wen_b}),
                144'({4'h0, 4'hF, 1'b0}));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_index_data", {refill_index, refill_din}, e);
          end
          last_wr_cyc = cyc;
        end else begin
          check("idle_strobes", 144'({refill_bank_cen_b, refill_bank_clk_en, refill_wen_b}),
                144'({4'hF, 4'h0, 1'b1}));
        end
        if (refill_done) begin
          check("done_expected", 144'(exp_done_q.size() != 0), 144'(1));
          check("done_after_last_wr", 144'(cyc - last_wr_cyc), 144'(1));
          if (exp_done_q.size() != 0) begin
            d = exp_done_q.pop_front();
            check("done_index", 144'(refill_index), 144'(d));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int req_cyc;

  task automatic send_req(input logic [9:0] idx);
    logic ok;
    ok = 1'b0;
    refill_req_vld   = 1'b1;
    refill_req_index = idx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (refill_req_rdy) begin
        ok = 1'b1;
        req_cyc = cyc;
        break;
      end
    end
    check("req_handshake", 144'(ok), 144'(1));
    @(posedge clk);
    #1;
    refill_req_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d);
    logic ok;
    ok = 1'b0;
    l2_refill_data_vld = 1'b1;
    l2_refill_data     = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (l2_refill_data_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check("beat_handshake", 144'(ok), 144'(1));
    @(posedge clk);
    #1;
    l2_refill_data_vld = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    logic ok;
    ok = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (refill_done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 144'(ok), 144'(1));
    check("req_rdy_at_done", 144'(refill_req_rdy), 144'(0));
    @(negedge clk);
    check("req_rdy_after_done", 144'(refill_req_rdy), 144'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},
          144'({refill_req_rdy, l2_refill_data_rdy, refill_wr_vld, refill_done, refill_busy,
                refill_bank_cen_b, refill_bank_clk_en, refill_wen_b}),
          144'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1}));
    check({tag, "_index_din"}, {refill_index, refill_din}, 144'(0));
    check({tag, "_state"}, 144'(refill_dbg_state), 144'(REFILL_IDLE));
  endtask

  // ---------------- stimulus ----------------
  int done_cyc;

  initial begin
    rst_n                   = 1'b0;
    refill_req_vld          = 1'b0;
    refill_req_index        = '0;
    l2_refill_data_vld      = 1'b0;
    l2_refill_data          = '0;
    ifu_fetch_rd_vld        = 1'b0;
    ifu_icache_refill_flush = 1'b0;
    n_checks = 0;
    n_pass   = 0;
    last_wr_cyc = 0;

    @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");
    @(posedge clk);
    #1;

    // Single refill, no fetch; a second request is held throughout and must be ignored.
    push_line(10'h155, 128'hA0A0A0A0_00000000_11111111_22222222,
              128'hA1A1A1A1_33333333_44444444_55555555,
              128'hA2A2A2A2_66666666_77777777_88888888,
              128'hA3A3A3A3_99999999_AAAAAAAA_BBBBBBBB);
    send_req(10'h155);
    refill_req_vld   = 1'b1;
    refill_req_index = 10'h3FF;
    send_beat(128'hA0A0A0A0_00000000_11111111_22222222);
    send_beat(128'hA1A1A1A1_33333333_44444444_55555555);
    send_beat(128'hA2A2A2A2_66666666_77777777_88888888);
    send_beat(128'hA3A3A3A3_99999999_AAAAAAAA_BBBBBBBB);
    refill_req_vld = 1'b0;
    wait_done(done_cyc);
    check("done_latency", 144'(done_cyc - req_cyc), 144'(6));

    // Fetch stall for 3 cycles while beat 1 is buffered.
    push_line(10'h0AA, 128'hB0B0B0B0_01020304_05060708_090A0B0C,
              128'hB1B1B1B1_DEADBEEF_CAFEF00D_12345678,
              128'hB2B2B2B2_0F0F0F0F_F0F0F0F0_00FF00FF,
              128'hB3B3B3B3_FFFFFFFF_00000000_FFFFFFFF);
    send_req(10'h0AA);
    @(negedge clk);
    check("fill_state", 144'(refill_dbg_state), 144'(REFILL_FILL));
    check("fill_rdy", 144'({refill_req_rdy, refill_busy, l2_refill_data_rdy}), 144'(3'b011));
    @(posedge clk);
    #1;
    send_beat(128'hB0B0B0B0_01020304_05060708_090A0B0C);
    send_beat(128'hB1B1B1B1_DEADBEEF_CAFEF00D_12345678);
    ifu_fetch_rd_vld   = 1'b1;
    l2_refill_data_vld = 1'b1;
    l2_refill_data     = 128'hB2B2B2B2_0F0F0F0F_F0F0F0F0_00FF00FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_no_write", 144'({refill_wr_vld, refill_bank_cen_b}), 144'({1'b0, 4'hF}));
      check("stall_rdy_low", 144'(l2_refill_data_rdy), 144'(0));
      @(posedge clk);
      #1;
    end
    ifu_fetch_rd_vld = 1'b0;
    @(negedge clk);
    check("stall_resume", 144'({refill_wr_vld, l2_refill_data_rdy}), 144'(2'b11));
    @(posedge clk);
    #1;
    l2_refill_data_vld = 1'b0;
    send_beat(128'hB3B3B3B3_FFFFFFFF_00000000_FFFFFFFF);
    wait_done(done_cyc);

    // Flush after two writes; flush also suppresses the write of a buffered beat.
    exp_q.push_back({16'hB0C0, 128'hC0C0C0C0_10101010_20202020_30303030});
    exp_q.push_back({16'hB0D0, 128'hC1C1C1C1_40404040_50505050_60606060});
    send_req(10'h2C3);
    send_beat(128'hC0C0C0C0_10101010_20202020_30303030);
    send_beat(128'hC1C1C1C1_40404040_50505050_60606060);
    send_beat(128'hC2C2C2C2_70707070_80808080_90909090);
    ifu_icache_refill_flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_write", 144'({refill_wr_vld, refill_bank_cen_b, refill_wen_b}),
          144'({1'b0, 4'hF, 1'b1}));
    @(posedge clk);
    #1;
    ifu_icache_refill_flush = 1'b0;
    l2_refill_data_vld      = 1'b1;
    l2_refill_data          = 128'hC3C3C3C3_A0A0A0A0_B0B0B0B0_C0C0C0C0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_flush_idle",
            144'({refill_busy, refill_done, refill_req_rdy, l2_refill_data_rdy}), 144'(4'b0010));
      @(posedge clk);
      #1;
    end
    l2_refill_data_vld = 1'b0;
    push_line(10'h001, 128'hD0D0D0D0_00000001_00000002_00000003,
              128'hD1D1D1D1_00000004_00000005_00000006,
              128'hD2D2D2D2_00000007_00000008_00000009,
              128'hD3D3D3D3_0000000A_0000000B_0000000C);
    send_req(10'h001);
    send_beat(128'hD0D0D0D0_00000001_00000002_00000003);
    send_beat(128'hD1D1D1D1_00000004_00000005_00000006);
    send_beat(128'hD2D2D2D2_00000007_00000008_00000009);
    send_beat(128'hD3D3D3D3_0000000A_0000000B_0000000C);
    wait_done(done_cyc);

`ifdef ICACHE_REFILL_PARITY_EN
    // Bank0 word 1 and bank3 word 80000000 have odd weight; banks 1 and 2 are even.
    push_line(10'h000, 128'h00000001_00000003_00000000_80000000, 128'h0, 128'h0, 128'h0);
    send_req(10'h000);
    send_beat(128'h00000001_00000003_00000000_80000000);
    @(negedge clk);
    check("parity_bits", 144'(refill_par), 144'(4'b1001));
    @(posedge clk);
    #1;
    send_beat(128'h0);
    send_beat(128'h0);
    send_beat(128'h0);
    wait_done(done_cyc);
`endif

    // Asynchronous reset mid-FILL with the buffer held full by a fetch.
    send_req(10'h3FF);
    ifu_fetch_rd_vld = 1'b1;
    send_beat(128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3);
    @(negedge clk);
    check("full_buf_stalled", 144'({refill_wr_vld, l2_refill_data_rdy, refill_busy}), 144'(3'b001));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    ifu_fetch_rd_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("after_async_reset");

    check("exp_q_drained", 144'(exp_q.size()), 144'(0));
    check("exp_done_q_drained", 144'(exp_done_q.size()), 144'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
